// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vga_capture
//  Purpose  : VGA output sink. Samples HS/VS/BLANK/RGB on the pixel strobe,
//             measures frame geometry against H_ACTIVE x V_ACTIVE and, once a
//             clean frame has been seen, re-emits the visible pixels of the
//             following frames as a ready/valid stream through a small FIFO.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             pix_en                 - pixel strobe (inputs sampled when 1)
//             vga_hs/vs/blank/r/g/b  - VGA input (syncs active-low, BLANK_N)
//             out_data/valid/ready   - pixel stream {R,G,B} or {Y,Y,Y}
//             out_sop/out_eop        - first / last pixel of a frame
//             x_pos, y_pos           - current column count and line
//             locked, geom_err       - geometry status / mismatch pulse
//             overflow, clr_err      - sticky FIFO drop flag and its clear
//  Options  : CAPTURE_GRAY_EN - emit luma {Y,Y,Y} through an extra register
//             stage; undefined emits {R,G,B} with no multipliers.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int XW         = 10,
    parameter int YW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          vga_hs,
    input  logic          vga_vs,
    input  logic          vga_blank,
    input  logic [7:0]    vga_r,
    input  logic [7:0]    vga_g,
    input  logic [7:0]    vga_b,
    output logic [23:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sop,
    output logic          out_eop,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic          locked,
    output logic          geom_err,
    output logic          overflow,
    input  logic          clr_err
);

    localparam int            c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_WAIT_ACT = 2'd1;
    localparam logic [1:0]    c_ACTIVE   = 2'd2;
    localparam logic [XW-1:0] c_X_FULL   = XW'(H_ACTIVE);
    localparam logic [XW-1:0] c_X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] c_Y_FULL   = YW'(V_ACTIVE);
    localparam logic [YW-1:0] c_Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [c_AW:0] c_CNT_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0] c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    // ------------------------------------------------------------------
    // Sampled copies of the sync/blank inputs, advanced on pix_en only
    // ------------------------------------------------------------------
    logic r_vs_q, r_hs_q, r_blank_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_q    <= 1'b0;
            r_hs_q    <= 1'b0;
            r_blank_q <= 1'b0;
        end else if (pix_en) begin
            r_vs_q    <= vga_vs;
            r_hs_q    <= vga_hs;
            r_blank_q <= vga_blank;
        end
    end

    logic w_vs_fall, w_line_end, w_visible;
    assign w_vs_fall  = pix_en & r_vs_q & ~vga_vs;
    assign w_line_end = pix_en & r_blank_q & ~vga_blank;
    // A visible sample that coincides with a VS fall is discarded.
    assign w_visible  = pix_en & vga_blank & ~w_vs_fall;

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_locked, r_fwd, r_frame_err, r_geom_err, r_overflow;
    logic          w_drop;

    // Coordinates of the pixel being sampled this cycle. The sample that
    // moves WAIT_ACT -> ACTIVE is pixel (0,0) regardless of stale counters.
    logic [XW-1:0] w_cur_x;
    logic [YW-1:0] w_cur_y;
    assign w_cur_x = (r_state == c_ACTIVE) ? r_x : '0;
    assign w_cur_y = (r_state == c_ACTIVE) ? r_y : '0;

    logic w_pix_wr, w_pix_sop, w_pix_eop;
    assign w_pix_wr  = w_visible & (((r_state == c_ACTIVE)   & r_fwd) |
                                    ((r_state == c_WAIT_ACT) & r_locked));
    assign w_pix_sop = (w_cur_x == '0) & (w_cur_y == '0);
    assign w_pix_eop = (w_cur_x == c_X_LAST) & (w_cur_y == c_Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_locked    <= 1'b0;
            r_fwd       <= 1'b0;
            r_frame_err <= 1'b0;
            r_geom_err  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_geom_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_vs_fall) r_state <= c_WAIT_ACT;
                end
                c_WAIT_ACT: begin
                    if (w_vs_fall) begin
                        // A frame that never showed a visible line.
                        r_geom_err <= 1'b1;
                        r_locked   <= 1'b0;
                    end else if (w_visible) begin
                        // Counters restart at (0,0); the entry sample is
                        // itself visible, so it is already counted in x.
                        r_state     <= c_ACTIVE;
                        r_x         <= XW'(1);
                        r_y         <= '0;
                        r_fwd       <= r_locked;
                        r_frame_err <= 1'b0;
                    end
                end
                c_ACTIVE: begin
                    if (w_vs_fall) begin
                        r_state    <= c_WAIT_ACT;
                        r_geom_err <= (r_y != c_Y_FULL) | vga_blank;
                        r_locked   <= ~r_frame_err & (r_y == c_Y_FULL) & ~vga_blank;
                    end else begin
                        if (w_visible && r_x != '1) r_x <= r_x + XW'(1);
                        if (w_line_end) begin
                            if (r_x != c_X_FULL) begin
                                r_geom_err  <= 1'b1;
                                r_locked    <= 1'b0;
                                r_frame_err <= 1'b1;
                            end
                            r_x <= '0;
                            if (r_y != '1) r_y <= r_y + YW'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
            // A drop stops forwarding until the next frame start so that a
            // truncated frame never produces an EOP.
            if (w_drop) r_fwd <= 1'b0;
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pixel formatting ahead of the FIFO write port
    // ------------------------------------------------------------------
    logic        w_wr_req, w_wr_sop, w_wr_eop;
    logic [23:0] w_wr_data;
    logic        w_unused;

`ifdef CAPTURE_GRAY_EN
    logic [15:0] w_acc;
    logic        r_stg_wr, r_stg_sop, r_stg_eop;
    logic [23:0] r_stg_data;

    // Coefficients sum to 256, so the 16-bit accumulator cannot overflow.
    assign w_acc = (16'd77  * {8'd0, vga_r}) +
                   (16'd150 * {8'd0, vga_g}) +
                   (16'd29  * {8'd0, vga_b});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg_wr   <= 1'b0;
            r_stg_sop  <= 1'b0;
            r_stg_eop  <= 1'b0;
            r_stg_data <= '0;
        end else begin
            // A pixel entering the stage on the drop cycle belongs to the
            // frame being abandoned.
            r_stg_wr   <= w_pix_wr & ~w_drop;
            r_stg_sop  <= w_pix_sop;
            r_stg_eop  <= w_pix_eop;
            r_stg_data <= {w_acc[15:8], w_acc[15:8], w_acc[15:8]};
        end
    end

    assign w_wr_req  = r_stg_wr;
    assign w_wr_sop  = r_stg_sop;
    assign w_wr_eop  = r_stg_eop;
    assign w_wr_data = r_stg_data;
    assign w_unused  = ^{r_hs_q, w_acc[7:0]};
`else
    assign w_wr_req  = w_pix_wr;
    assign w_wr_sop  = w_pix_sop;
    assign w_wr_eop  = w_pix_eop;
    assign w_wr_data = {vga_r, vga_g, vga_b};
    assign w_unused  = r_hs_q;
`endif

    // ------------------------------------------------------------------
    // Output FIFO: {data, sop, eop} per entry
    // ------------------------------------------------------------------
    logic [25:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_rd, w_wr, w_full;
    logic [25:0]     w_head;

    assign w_full = (r_count == c_CNT_FULL);
    assign w_rd   = out_valid & out_ready;
    // A read in the same cycle frees the slot the write needs.
    assign w_drop = w_wr_req & w_full & ~w_rd;
    assign w_wr   = w_wr_req & ~w_drop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_wr_data, w_wr_sop, w_wr_eop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    // Head entry is masked while empty so every output reads 0 after reset.
    assign out_data  = out_valid ? w_head[25:2] : '0;
    assign out_sop   = out_valid & w_head[1];
    assign out_eop   = out_valid & w_head[0];

    assign x_pos    = r_x;
    assign y_pos    = r_y;
    assign locked   = r_locked;
    assign geom_err = r_geom_err;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_capture
//  Purpose  : Self-checking bench for vga_capture using a reduced 8x4 frame
//             and a 4-entry FIFO. A table of frame scenarios is applied in
//             order; reset, error-clear and luma cases are hand sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

    localparam int c_H = 8;
    localparam int c_V = 4;
    localparam int c_D = 4;
`ifdef CAPTURE_GRAY_EN
    localparam bit c_GRAY = 1'b1;
`else
    localparam bit c_GRAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_blank = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic [23:0] out_data;
    logic        out_valid, out_ready = 1'b1, out_sop, out_eop;
    logic [9:0]  x_pos, y_pos;
    logic        locked, geom_err, overflow;
    logic        clr_err = 1'b0;

    vga_capture #(
        .H_ACTIVE(c_H), .V_ACTIVE(c_V), .FIFO_DEPTH(c_D), .XW(10), .YW(10)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop),
        .x_pos(x_pos), .y_pos(y_pos),
        .locked(locked), .geom_err(geom_err), .overflow(overflow),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        int short_line;   // line index with one pixel missing, -1 for none
        bit ready;        // out_ready during the frame
        bit fwd;          // frame expected to be forwarded
        int keep;         // number of forwarded pixels that fit
        int clr_pix;      // visible pixel index at which clr_err meets the drop
        int exp_beats;
        bit exp_locked;
        int exp_geom;
        bit exp_ovf;
    } row_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats    = 0;
    int    geom_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel-strobe slot: pix_en high for one clock, low for the next.
    // clr_err is placed on whichever edge the FIFO write for this pixel uses.
    task automatic sample(input logic vs, input logic blank, input logic [23:0] rgb, input bit clr_on);
        vga_vs    = vs;
        vga_blank = blank;
        vga_hs    = blank;
        {vga_r, vga_g, vga_b} = rgb;
        pix_en    = 1'b1;
        clr_err   = clr_on & ~c_GRAY;
        tick();
        pix_en    = 1'b0;
        clr_err   = clr_on & c_GRAY;
        tick();
        clr_err   = 1'b0;
    endtask

    function automatic logic [23:0] luma(input logic [23:0] rgb);
        int a;
        logic [7:0] y;
        a = 77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0]);
        y = 8'(a >> 8);
        return {y, y, y};
    endfunction

    // Lines of visible pixels followed by a trailing VS fall that closes the frame.
    task automatic send_frame(input int tag, input int short_line, input bit fwd,
                              input int keep, input int clr_pix);
        int k;
        int n;
        logic [23:0] rgb;
        beat_t e;
        k = 0;
        for (int y = 0; y < c_V; y++) begin
            n = (y == short_line) ? c_H - 1 : c_H;
            for (int x = 0; x < n; x++) begin
                if (y == 0 && x == 0)      rgb = 24'hFF0000;
                else if (y == 0 && x == 1) rgb = 24'hFFFFFF;
                else rgb = {8'(x * 16 + y), 8'(y * 40 + tag), 8'(x * 3 + tag * 5)};
                if (fwd && k < keep) begin
                    if (!c_GRAY)               e.data = rgb;
                    else if (y == 0 && x == 0) e.data = 24'h4C4C4C;
                    else if (y == 0 && x == 1) e.data = 24'hFFFFFF;
                    else                       e.data = luma(rgb);
                    e.sop = (x == 0 && y == 0);
                    e.eop = (x == c_H - 1 && y == c_V - 1);
                    exp_q.push_back(e);
                end
                sample(1'b1, 1'b1, rgb, k == clr_pix);
                k++;
            end
            sample(1'b1, 1'b0, 24'h0, 1'b0);
            sample(1'b1, 1'b0, 24'h0, 1'b0);
        end
        sample(1'b1, 1'b0, 24'h0, 1'b0);
        sample(1'b0, 1'b0, 24'h0, 1'b0);
        sample(1'b1, 1'b0, 24'h0, 1'b0);
        sample(1'b1, 1'b0, 24'h0, 1'b0);
    endtask

    // Beat checker and geometry-pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        if (geom_err) geom_seen++;
        if (out_valid && out_ready) begin
            beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data=%h sop=%b eop=%b, required no beat",
                         out_data, out_sop, out_eop);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_sop, out_eop} !== {e.data, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                             out_data, out_sop, out_eop, e.data, e.sop, e.eop);
                end
            end
        end
    end

    task automatic apply_row(input int idx, input row_t row);
        string s;
        s = $sformatf("row%0d", idx);
        out_ready = row.ready;
        beats     = 0;
        geom_seen = 0;
        send_frame(idx, row.short_line, row.fwd, row.keep, row.clr_pix);
        if (!row.ready) begin
            check({s, "_held_no_beats"}, beats, 0);
            check({s, "_held_valid"}, out_valid, 1);
            out_ready = 1'b1;
        end
        repeat (20) tick();
        check({s, "_beats"}, beats, row.exp_beats);
        check({s, "_pending"}, exp_q.size(), 0);
        check({s, "_locked"}, locked, row.exp_locked);
        check({s, "_geom_pulses"}, geom_seen, row.exp_geom);
        check({s, "_overflow"}, overflow, row.exp_ovf);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_out_valid"}, out_valid, 0);
        check({p, "_out_data"}, out_data, 0);
        check({p, "_sop_eop"}, {out_sop, out_eop}, 0);
        check({p, "_x_pos"}, x_pos, 0);
        check({p, "_y_pos"}, y_pos, 0);
        check({p, "_locked"}, locked, 0);
        check({p, "_geom_err"}, geom_err, 0);
        check({p, "_overflow"}, overflow, 0);
    endtask

    row_t rows[9];

    initial begin
        //          short rdy fwd keep clr beats lock geom ovf
        rows[0] = '{-1, 1, 0, 999, -1,  0, 1, 0, 0};  // first measured frame
        rows[1] = '{-1, 1, 1, 999, -1, 32, 1, 0, 0};  // forwarded, sop/eop
        rows[2] = '{ 2, 1, 1, 999, -1, 31, 0, 1, 0};  // one 7-pixel line
        rows[3] = '{-1, 1, 0, 999, -1,  0, 1, 0, 0};  // not forwarded, relocks
        rows[4] = '{-1, 0, 1, c_D,  4,  4, 1, 0, 1};  // stalled: overflow, clr same cycle
        rows[5] = '{-1, 1, 1, 999, -1, 32, 1, 0, 1};  // full frame again, flag sticky
        rows[6] = '{-1, 1, 0, 999, -1,  0, 0, 0, 0};  // after reset: IDLE until VS
        rows[7] = '{-1, 1, 0, 999, -1,  0, 1, 0, 0};  // clean measured frame
        rows[8] = '{-1, 1, 1, 999, -1, 32, 1, 0, 0};  // capture resumes

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset");

        // Leading VS fall moves the capture out of IDLE.
        sample(1'b1, 1'b0, 24'h0, 1'b0);
        sample(1'b0, 1'b0, 24'h0, 1'b0);
        sample(1'b1, 1'b0, 24'h0, 1'b0);

        for (int i = 0; i < 6; i++) apply_row(i, rows[i]);

        // clr_err on its own clears the sticky flag.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_alone_overflow", overflow, 0);

        // Reset in the middle of a forwarded line with pixels queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b1, 24'h123456, 1'b0);
        repeat (2) tick();
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_x", x_pos, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        out_ready = 1'b1;
        tick();

        for (int i = 6; i < 9; i++) apply_row(i, rows[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
